// File: rtl/hdmi_video_timing_if.sv
`default_nettype none
// ============================================================================
//  Module   : hdmi_video_timing_if
//  Brief    : Raster timing bundle from hdmi_video_timing to the TMDS encoders
//             and the pixel source.
//  Revision : 1.0
// ============================================================================
interface hdmi_video_timing_if;
   logic [11:0] x;
   logic [11:0] y;
   logic        hsync;
   logic        vsync;
   logic        in_image;
   logic        in_guard;
   logic        pixel_req;
   logic        line_start;
   logic        frame_start;
   logic [1:0]  control0;
   logic [1:0]  control1;
   logic [1:0]  control2;

   modport master (
      output x, y, hsync, vsync, in_image, in_guard, pixel_req,
             line_start, frame_start, control0, control1, control2
   );

   modport slave (
      input  x, y, hsync, vsync, in_image, in_guard, pixel_req,
             line_start, frame_start, control0, control1, control2
   );
endinterface
`default_nettype wire

// File: rtl/hdmi_video_timing.sv
`default_nettype none
// ============================================================================
//  Module   : hdmi_video_timing
//  Brief    : Pixel-clock raster generator: position, syncs, active window and
//             TMDS control/guard qualifiers. Define HDMI_PREAMBLE_EN for the
//             HDMI preamble/guard band (H_BACK must then be >= 10); otherwise DVI.
//  Revision : 1.0
// ============================================================================
module hdmi_video_timing #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FRONT  = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BACK   = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FRONT  = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BACK   = 33,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic                clk,
   input  logic                reset,
   hdmi_video_timing_if.master vt
);

   localparam logic [11:0] C_H_LAST   = 12'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [11:0] C_V_LAST   = 12'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [11:0] C_H_ACT    = 12'(H_ACTIVE);
   localparam logic [11:0] C_V_ACT    = 12'(V_ACTIVE);
   localparam logic [11:0] C_HS_BEG   = 12'(H_ACTIVE + H_FRONT);
   localparam logic [11:0] C_HS_END   = 12'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [11:0] C_VS_BEG   = 12'(V_ACTIVE + V_FRONT);
   localparam logic [11:0] C_VS_END   = 12'(V_ACTIVE + V_FRONT + V_SYNC);
`ifdef HDMI_PREAMBLE_EN
   localparam logic [11:0] C_PRE_BEG  = C_H_LAST - 12'd9;
   localparam logic [11:0] C_PRE_END  = C_H_LAST - 12'd2;
   localparam logic [11:0] C_GRD_BEG  = C_H_LAST - 12'd1;
`endif

   logic [11:0] x_q, x_d;
   logic [11:0] y_q, y_d;
   logic [11:0] x2, y2;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        in_image_q, in_image_d;
   logic        in_guard_q, in_guard_d;
   logic        pixel_req_q, pixel_req_d;
   logic        line_start_q, line_start_d;
   logic        frame_start_q, frame_start_d;
   logic [1:0]  ctl_q, ctl_d;
`ifdef HDMI_PREAMBLE_EN
   logic        pre_line;
`endif

   // Every flag is decoded from the position the counters move to on this
   // edge, so all registered outputs describe the same (x, y).
   always_comb begin
      x_d = (x_q == C_H_LAST) ? 12'd0 : x_q + 12'd1;
      y_d = y_q;
      if (x_q == C_H_LAST) begin
         y_d = (y_q == C_V_LAST) ? 12'd0 : y_q + 12'd1;
      end

      x2 = (x_d == C_H_LAST) ? 12'd0 : x_d + 12'd1;
      y2 = y_d;
      if (x_d == C_H_LAST) begin
         y2 = (y_d == C_V_LAST) ? 12'd0 : y_d + 12'd1;
      end

      in_image_d    = (x_d < C_H_ACT) && (y_d < C_V_ACT);
      pixel_req_d   = (x2 < C_H_ACT) && (y2 < C_V_ACT);
      hsync_d       = ((x_d >= C_HS_BEG) && (x_d < C_HS_END)) ? SYNC_POL : !SYNC_POL;
      vsync_d       = ((y_d >= C_VS_BEG) && (y_d < C_VS_END)) ? SYNC_POL : !SYNC_POL;
      line_start_d  = (x_d == 12'd0);
      frame_start_d = (x_d == 12'd0) && (y_d == 12'd0);

`ifdef HDMI_PREAMBLE_EN
      // Preamble and guard lead into a line whose successor is active video.
      pre_line   = (y_d == C_V_LAST) || (y_d < C_V_ACT - 12'd1);
      ctl_d      = (pre_line && (x_d >= C_PRE_BEG) && (x_d <= C_PRE_END)) ? 2'b01 : 2'b00;
      in_guard_d = pre_line && (x_d >= C_GRD_BEG);
`else
      ctl_d      = 2'b00;
      in_guard_d = 1'b0;
`endif
   end

   // Reset parks the counters at the last raster position so release lands on (0, 0).
   always_ff @(posedge clk) begin
      if (reset) begin
         x_q           <= C_H_LAST;
         y_q           <= C_V_LAST;
         hsync_q       <= !SYNC_POL;
         vsync_q       <= !SYNC_POL;
         in_image_q    <= 1'b0;
         in_guard_q    <= 1'b0;
         pixel_req_q   <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         ctl_q         <= 2'b00;
      end else begin
         x_q           <= x_d;
         y_q           <= y_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         in_image_q    <= in_image_d;
         in_guard_q    <= in_guard_d;
         pixel_req_q   <= pixel_req_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         ctl_q         <= ctl_d;
      end
   end

   assign vt.x           = x_q;
   assign vt.y           = y_q;
   assign vt.hsync       = hsync_q;
   assign vt.vsync       = vsync_q;
   assign vt.in_image    = in_image_q;
   assign vt.in_guard    = in_guard_q;
   assign vt.pixel_req   = pixel_req_q;
   assign vt.line_start  = line_start_q;
   assign vt.frame_start = frame_start_q;
   assign vt.control0    = {vsync_q, hsync_q};
   assign vt.control1    = ctl_q;
   assign vt.control2    = ctl_q;

endmodule
`default_nettype wire

// File: tb/tb_hdmi_video_timing.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hdmi_video_timing
//  Brief    : Scoreboard bench: a reduced-raster instance and a default-timing
//             instance share clock and reset; expected outputs are queued per edge.
//  Revision : 1.0
// ============================================================================
module tb_hdmi_video_timing;

   localparam int SHA = 16, SHF = 4, SHS = 6, SHB = 12;
   localparam int SVA = 8,  SVF = 2, SVS = 2, SVB = 3;
   localparam int SHT = 38, SVT = 15;
   localparam int DHA = 640, DHF = 16, DHS = 96, DHB = 48;
   localparam int DVA = 480, DVF = 10, DVS = 2,  DVB = 33;
   localparam int DHT = 800, DVT = 525;

   typedef struct packed {
      logic [11:0] x;
      logic [11:0] y;
      logic        hs;
      logic        vs;
      logic        img;
      logic        grd;
      logic        preq;
      logic        ls;
      logic        fs;
      logic [1:0]  c0;
      logic [1:0]  c1;
      logic [1:0]  c2;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hdmi_video_timing_if s_if ();
   hdmi_video_timing_if d_if ();

   hdmi_video_timing #(
      .H_ACTIVE(SHA), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
      .V_ACTIVE(SVA), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
      .SYNC_POL(1'b0)
   ) u_small (
      .clk   (clk),
      .reset (rst),
      .vt    (s_if)
   );

   hdmi_video_timing u_dflt (
      .clk   (clk),
      .reset (rst),
      .vt    (d_if)
   );

   exp_t q_s[$];
   exp_t q_d[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   function automatic exp_t model(input bit in_rst, input int px, input int py,
                                  input int ha, input int hf, input int hs, input int hb,
                                  input int va, input int vf, input int vs, input int vb);
      exp_t e;
      int   ht, vt, sx, sy;
      ht = ha + hf + hs + hb;
      vt = va + vf + vs + vb;
      e  = '0;
      if (in_rst) begin
         e.x  = 12'(ht - 1);
         e.y  = 12'(vt - 1);
         e.hs = 1'b1;
         e.vs = 1'b1;
         e.c0 = 2'b11;
         return e;
      end
      e.x   = 12'(px);
      e.y   = 12'(py);
      e.img = (px < ha) && (py < va);
      sx    = (px == ht - 1) ? 0 : px + 1;
      sy    = (px == ht - 1) ? ((py == vt - 1) ? 0 : py + 1) : py;
      e.preq = (sx < ha) && (sy < va);
      e.hs  = !((px >= ha + hf) && (px < ha + hf + hs));
      e.vs  = !((py >= va + vf) && (py < va + vf + vs));
      e.ls  = (px == 0);
      e.fs  = (px == 0) && (py == 0);
      e.c0  = {e.vs, e.hs};
`ifdef HDMI_PREAMBLE_EN
      begin
         bit pre;
         pre = (py == vt - 1) || (py < va - 1);
         if (pre && (px >= ht - 10) && (px <= ht - 3)) begin
            e.c1 = 2'b01;
            e.c2 = 2'b01;
         end
         e.grd = pre && (px >= ht - 2);
      end
`endif
      return e;
   endfunction

   function automatic exp_t sample_s();
      return {s_if.x, s_if.y, s_if.hsync, s_if.vsync, s_if.in_image, s_if.in_guard,
              s_if.pixel_req, s_if.line_start, s_if.frame_start,
              s_if.control0, s_if.control1, s_if.control2};
   endfunction

   function automatic exp_t sample_d();
      return {d_if.x, d_if.y, d_if.hsync, d_if.vsync, d_if.in_image, d_if.in_guard,
              d_if.pixel_req, d_if.line_start, d_if.frame_start,
              d_if.control0, d_if.control1, d_if.control2};
   endfunction

   task automatic check_int(input string nm, input int got, input int want);
      n_vec++;
      if (got != want) begin
         n_miss++;
         $display("FAIL %s got=%0d want=%0d", nm, got, want);
      end
   endtask

   task automatic check_vec(input string nm, input exp_t got, input exp_t want);
      n_vec++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s at t=%0t got=%h want=%h (got x=%0d y=%0d, want x=%0d y=%0d)",
                  nm, $time, got, want, got.x, got.y, want.x, want.y);
      end
   endtask

   // Monitor: pops one expectation per instance every cycle, plus frame/line tallies.
   bit fs_seen   = 1'b0;
   int s_period  = 0;
   int s_img     = 0;
   int d_hs_low  = 0;
   int d_img     = 0;

   always @(negedge clk) begin
      if (q_s.size() > 0) check_vec("small_raster", sample_s(), q_s.pop_front());
      if (q_d.size() > 0) check_vec("default_raster", sample_d(), q_d.pop_front());

      if (s_if.x == 12'(SHT - 1) && s_if.y == 12'(SVT - 1) && !s_if.pixel_req) begin
         fs_seen = 1'b0;
      end else if (s_if.frame_start) begin
         if (fs_seen) begin
            check_int("small_frame_period", s_period, SHT * SVT);
            check_int("small_image_cycles", s_img, SHA * SVA);
         end
         fs_seen  = 1'b1;
         s_period = 0;
         s_img    = 0;
      end
      if (fs_seen) begin
         s_period++;
         if (s_if.in_image) s_img++;
      end

      if (d_if.y == 12'd0) begin
         if (d_if.x == 12'd0) begin
            d_hs_low = 0;
            d_img    = 0;
         end
         if (!d_if.hsync)   d_hs_low++;
         if (d_if.in_image) d_img++;
         if (d_if.x == 12'd799) begin
            check_int("default_line0_hsync_low", d_hs_low, 96);
            check_int("default_line0_image", d_img, 640);
         end
      end
   end

   // Driver: reference raster position advanced in step with each edge.
   bit m_rst = 1'b1;
   int spx = 0, spy = 0, dpx = 0, dpy = 0;

   task automatic adv(inout int px, inout int py, input int ht, input int vt);
      if (px == ht - 1) begin
         px = 0;
         py = (py == vt - 1) ? 0 : py + 1;
      end else begin
         px = px + 1;
      end
   endtask

   task automatic step(input bit r);
      @(negedge clk);
      rst = r;
      @(posedge clk);
      if (r) begin
         m_rst = 1'b1;
      end else if (m_rst) begin
         m_rst = 1'b0;
         spx = 0; spy = 0; dpx = 0; dpy = 0;
      end else begin
         adv(spx, spy, SHT, SVT);
         adv(dpx, dpy, DHT, DVT);
      end
      q_s.push_back(model(m_rst, spx, spy, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB));
      q_d.push_back(model(m_rst, dpx, dpy, DHA, DHF, DHS, DHB, DVA, DVF, DVS, DVB));
   endtask

   initial begin
      repeat (5) step(1'b1);
      repeat (2 * SHT * SVT + 20) step(1'b0);
      repeat (3 * SHT + 7) step(1'b0);
      step(1'b1);
      repeat (SHT * SVT + 10) step(1'b0);
      repeat (2) @(negedge clk);
      #1;
      check_int("small_queue_drained", q_s.size(), 0);
      check_int("default_queue_drained", q_d.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
